id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 92 +++++++++
 tb/tb_id_ex_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode/execute boundary: register file, load-use stall and ID/EX bundle.
// Optional macro ID_EX_WB_BYPASS_EN forwards same-cycle writeback to reads.
module id_ex_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] opcode,
   input  logic [3:0] A_reg_address,
   input  logic [3:0] B_reg_address,
   input  logic [3:0] W_reg_address,
   input  logic [3:0] Sign,
   input  logic [7:0] next_pc_address,
   input  logic       flush,
   input  logic       wb_en,
   input  logic [3:0] wb_addr,
   input  logic [7:0] wb_data,
   output logic       stall,
   output logic       ex_valid,
   output logic [3:0] ex_opcode,
   output logic [7:0] ex_a_data,
   output logic [7:0] ex_b_data,
   output logic [3:0] ex_w_addr,
   output logic [3:0] ex_sign,
   output logic [7:0] ex_pc
);

   localparam logic [3:0] OP_LOAD = 4'b1000;
   localparam logic [3:0] OP_NOP  = 4'b0000;

   logic [7:0] r_rf [16];
   logic [7:0] w_a_data;
   logic [7:0] w_b_data;
   logic       w_hazard;
   logic       w_bubble;
   logic       w_wr;

   assign w_wr = wb_en && (wb_addr != 4'd0);

`ifdef ID_EX_WB_BYPASS_EN
   always_comb begin
      w_a_data = r_rf[A_reg_address];
      w_b_data = r_rf[B_reg_address];
      if (w_wr && (wb_addr == A_reg_address)) w_a_data = wb_data;
      if (w_wr && (wb_addr == B_reg_address)) w_b_data = wb_data;
      if (A_reg_address == 4'd0) w_a_data = 8'd0;
      if (B_reg_address == 4'd0) w_b_data = 8'd0;
   end
`else
   always_comb begin
      w_a_data = r_rf[A_reg_address];
      w_b_data = r_rf[B_reg_address];
      if (A_reg_address == 4'd0) w_a_data = 8'd0;
      if (B_reg_address == 4'd0) w_b_data = 8'd0;
   end
`endif

   // Load result is not ready until after execute; hold decode one cycle.
   assign w_hazard = ex_valid && (ex_opcode == OP_LOAD) &&
                     (ex_w_addr != 4'd0) &&
                     ((ex_w_addr == A_reg_address) ||
                      (ex_w_addr == B_reg_address));
   assign stall    = w_hazard && !flush;
   assign w_bubble = flush || stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_rf[i] <= 8'd0;
      end else if (w_wr) begin
         r_rf[wb_addr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_bubble) begin
         ex_valid  <= 1'b0;
         ex_opcode <= OP_NOP;
         ex_a_data <= 8'd0;
         ex_b_data <= 8'd0;
         ex_w_addr <= 4'd0;
         ex_sign   <= 4'd0;
         ex_pc     <= 8'd0;
      end else begin
         ex_valid  <= 1'b1;
         ex_opcode <= opcode;
         ex_a_data <= w_a_data;
         ex_b_data <= w_b_data;
         ex_w_addr <= W_reg_address;
         ex_sign   <= Sign;
         ex_pc     <= next_pc_address;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
// Build with or without ID_EX_WB_BYPASS_EN; expectations follow the macro.
module tb_id_ex_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] opcode, A_reg_address, B_reg_address, W_reg_address, Sign;
   logic [7:0] next_pc_address;
   logic       flush, wb_en;
   logic [3:0] wb_addr;
   logic [7:0] wb_data;
   logic       stall, ex_valid;
   logic [3:0] ex_opcode, ex_w_addr, ex_sign;
   logic [7:0] ex_a_data, ex_b_data, ex_pc;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .opcode(opcode),
      .A_reg_address(A_reg_address), .B_reg_address(B_reg_address),
      .W_reg_address(W_reg_address), .Sign(Sign),
      .next_pc_address(next_pc_address), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_a_data(ex_a_data), .ex_b_data(ex_b_data),
      .ex_w_addr(ex_w_addr), .ex_sign(ex_sign), .ex_pc(ex_pc)
   );

   // Reference model: architectural register array plus expected ex bundle.
   logic [7:0] m_rf [16];
   logic       m_init = 1'b0;
   logic       m_valid;
   logic [3:0] m_op, m_w, m_sign;
   logic [7:0] m_a, m_b, m_pc;

   function automatic logic m_stall();
      if (flush) return 1'b0;
      if (!m_valid || m_op != 4'd8 || m_w == 4'd0) return 1'b0;
      return (m_w == A_reg_address) || (m_w == B_reg_address);
   endfunction

   function automatic logic [7:0] m_read(input logic [3:0] ad);
      if (ad == 4'd0) return 8'd0;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_en && wb_addr == ad) return wb_data;
`endif
      return m_rf[ad];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_init = 1'b1;
         for (int i = 0; i < 16; i++) m_rf[i] = 8'd0;
         {m_valid, m_op, m_w, m_sign, m_a, m_b, m_pc} = '0;
      end else if (m_init) begin
         if (m_stall() || flush) begin
            {m_valid, m_op, m_w, m_sign, m_a, m_b, m_pc} = '0;
         end else begin
            m_valid = 1'b1;
            m_op    = opcode;
            m_w     = W_reg_address;
            m_sign  = Sign;
            m_a     = m_read(A_reg_address);
            m_b     = m_read(B_reg_address);
            m_pc    = next_pc_address;
         end
         if (wb_en && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
      end
   end

   task automatic chk(input string nm, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Single compare process against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_init) begin
         chk("stall", {7'd0, stall}, {7'd0, m_stall()});
         chk("ex_valid", {7'd0, ex_valid}, {7'd0, m_valid});
         chk("ex_opcode", {4'd0, ex_opcode}, {4'd0, m_op});
         chk("ex_a_data", ex_a_data, m_a);
         chk("ex_b_data", ex_b_data, m_b);
         chk("ex_w_addr", {4'd0, ex_w_addr}, {4'd0, m_w});
         chk("ex_sign", {4'd0, ex_sign}, {4'd0, m_sign});
         chk("ex_pc", ex_pc, m_pc);
      end
   end

   task automatic drive(input logic rs, input logic [3:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] w, input logic [7:0] pc,
                        input logic fl, input logic we,
                        input logic [3:0] wa, input logic [7:0] wd);
      @(posedge clk);
      #2;
      reset = rs; opcode = op; A_reg_address = a; B_reg_address = b;
      W_reg_address = w; Sign = 4'h0; next_pc_address = pc;
      flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
      #1;
   endtask

   task automatic idle();
      drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
   endtask

   initial begin
      reset = 1'b1; opcode = '0; A_reg_address = '0; B_reg_address = '0;
      W_reg_address = '0; Sign = '0; next_pc_address = '0;
      flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

      // reset, write R3, read it back next cycle
      drive(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
      drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 4'h3, 8'h5A);
      chk("rst_valid", {7'd0, ex_valid}, 8'd0);
      chk("rst_stall", {7'd0, stall}, 8'd0);
      chk("rst_pc", ex_pc, 8'd0);
      drive(0, 4'h1, 4'h3, 4'h0, 4'h6, 8'h10, 0, 0, 4'h0, 8'h00);
      idle();
      chk("r027_a", ex_a_data, 8'h5A);
      chk("r027_b", ex_b_data, 8'h00);
      chk("r027_valid", {7'd0, ex_valid}, 8'd1);
      chk("r027_pc", ex_pc, 8'h10);

      // load-use hazard
      drive(0, 4'h8, 4'h0, 4'h0, 4'h5, 8'h12, 0, 0, 4'h0, 8'h00);
      drive(0, 4'h1, 4'h5, 4'h2, 4'h6, 8'h14, 0, 0, 4'h0, 8'h00);
      chk("r028_stall", {7'd0, stall}, 8'd1);
      drive(0, 4'h1, 4'h5, 4'h2, 4'h6, 8'h14, 0, 0, 4'h0, 8'h00);
      chk("r028_bubble", {7'd0, ex_valid}, 8'd0);
      chk("r028_nostall", {7'd0, stall}, 8'd0);
      idle();
      chk("r028_issue_v", {7'd0, ex_valid}, 8'd1);
      chk("r028_issue_op", {4'd0, ex_opcode}, 8'd1);

      // R0 exempt from hazard
      drive(0, 4'h8, 4'h0, 4'h0, 4'h0, 8'h16, 0, 0, 4'h0, 8'h00);
      drive(0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h18, 0, 0, 4'h0, 8'h00);
      chk("r029_stall", {7'd0, stall}, 8'd0);

      // flush, and flush during stall
      drive(0, 4'h2, 4'h1, 4'h1, 4'h1, 8'h1A, 1, 0, 4'h0, 8'h00);
      idle();
      chk("r030_valid", {7'd0, ex_valid}, 8'd0);
      chk("r030_op", {4'd0, ex_opcode}, 8'd0);
      drive(0, 4'h8, 4'h0, 4'h0, 4'h4, 8'h1C, 0, 0, 4'h0, 8'h00);
      drive(0, 4'h1, 4'h4, 4'h0, 4'h1, 8'h1E, 1, 0, 4'h0, 8'h00);
      chk("r030_fl_stall", {7'd0, stall}, 8'd0);
      idle();
      chk("r030_fl_bub", {7'd0, ex_valid}, 8'd0);

      // same-cycle write and read of R7
      drive(1, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
      drive(0, 4'h1, 4'h7, 4'h0, 4'h1, 8'h20, 0, 1, 4'h7, 8'hC3);
      drive(0, 4'h1, 4'h7, 4'h0, 4'h1, 8'h22, 0, 0, 4'h0, 8'h00);
`ifdef ID_EX_WB_BYPASS_EN
      chk("r031_a", ex_a_data, 8'hC3);
`else
      chk("r031_a", ex_a_data, 8'h00);
`endif
      idle();
      chk("r031_next", ex_a_data, 8'hC3);

      // R0 hardwired, then reset in the middle of a stall
      drive(0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 1, 4'h0, 8'hFF);
      drive(0, 4'h1, 4'h0, 4'h0, 4'h1, 8'h24, 0, 1, 4'h4, 8'h11);
      idle();
      chk("r032_r0", ex_a_data, 8'h00);
      drive(0, 4'h8, 4'h0, 4'h0, 4'h4, 8'h26, 0, 0, 4'h0, 8'h00);
      drive(1, 4'h1, 4'h4, 4'h0, 4'h1, 8'h28, 0, 1, 4'h5, 8'h77);
      drive(0, 4'h1, 4'h4, 4'h5, 4'h1, 8'h2A, 0, 0, 4'h0, 8'h00);
      chk("r032_valid", {7'd0, ex_valid}, 8'd0);
      chk("r032_pc", ex_pc, 8'd0);
      chk("r032_stall", {7'd0, stall}, 8'd0);
      idle();
      chk("r032_r4", ex_a_data, 8'h00);
      chk("r032_r5", ex_b_data, 8'h00);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 2) == 0) ? 4'h8 : 4'($urandom),
               4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)), 8'($urandom),
               ($urandom_range(0, 9) == 0), 1'($urandom),
               4'($urandom_range(0, 7)), 8'($urandom));
      end
      idle();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
